// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: scan states, common-anode polarity constants and the anode one-hot helper
package seg_pkg;
    typedef enum logic {S_BLANK, S_DRIVE} state_t;
    localparam logic ANODE_OFF = 1'b1;
    localparam logic SEG_OFF = 1'b1;
    function automatic logic [7:0] onehot_low(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display data, enables and scan outputs between host and scan controller
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [3:0]              dig_code;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    dp_n;
    logic                    frame_done;
    modport master (output digits_in, dp_in, digit_en, load, input dig_code, an_n, dp_n, frame_done);
    modport slave (input digits_in, dp_in, digit_en, load, output dig_code, an_n, dp_n, frame_done);
endinterface

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: free-running slot counter that wraps to zero at a programmable terminal count
module seg_slot_timer #(parameter int W = 16) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_term,
    output logic         o_tc,
    output logic [W-1:0] o_cnt_nxt
);
    logic [W-1:0] r_cnt;
    assign o_tc = r_cnt == i_term;
    assign o_cnt_nxt = o_tc ? '0 : r_cnt + 1'b1;
    always_ff @(posedge i_clk)
        r_cnt <= !i_rst_n ? '0 : o_cnt_nxt;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: blanked, double-buffered time-multiplexed scan of common-anode 7-segment digits
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic            i_clk,
    input logic            i_rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] BLANK_TERM = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_TERM = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    state_t                  r_state, w_state_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] r_pend_dig, r_act_dig, w_act_dig_nxt;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp, w_act_dp_nxt;
    logic [NUM_DIGITS-1:0]   r_an_n, w_an_nxt;
    logic [3:0]              r_code;
    logic                    r_dp_n, r_frame_done;
    logic                    w_tc, w_frame_end, w_on_nxt, w_last_nxt;
    logic [CW-1:0]           w_term, w_cnt_nxt;

    assign w_term = r_state == S_DRIVE ? DRIVE_TERM : BLANK_TERM;

    seg_slot_timer #(.W(CW)) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_term    (w_term),
        .o_tc      (w_tc),
        .o_cnt_nxt (w_cnt_nxt)
    );

    // Outputs are registered from next-state values so they line up with the state they describe
    always_comb begin
        w_frame_end   = r_state == S_DRIVE && w_tc && r_idx == LAST_IDX;
        w_state_nxt   = w_tc ? (r_state == S_BLANK ? S_DRIVE : S_BLANK) : r_state;
        w_idx_nxt     = (r_state == S_DRIVE && w_tc) ? (r_idx == LAST_IDX ? '0 : r_idx + 1'b1) : r_idx;
        w_act_dig_nxt = w_frame_end ? (bus.load ? bus.digits_in : r_pend_dig) : r_act_dig;
        w_act_dp_nxt  = w_frame_end ? (bus.load ? bus.dp_in : r_pend_dp) : r_act_dp;
        w_on_nxt      = w_state_nxt == S_DRIVE && bus.digit_en[w_idx_nxt];
        w_an_nxt      = w_on_nxt ? NUM_DIGITS'(onehot_low(3'(w_idx_nxt))) : {NUM_DIGITS{ANODE_OFF}};
        w_last_nxt    = w_state_nxt == S_DRIVE && w_cnt_nxt == DRIVE_TERM && w_idx_nxt == LAST_IDX;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_BLANK;
            r_idx        <= '0;
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_an_n       <= {NUM_DIGITS{ANODE_OFF}};
            r_dp_n       <= SEG_OFF;
            r_code       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pend_dig   <= bus.load ? bus.digits_in : r_pend_dig;
            r_pend_dp    <= bus.load ? bus.dp_in : r_pend_dp;
            r_act_dig    <= w_act_dig_nxt;
            r_act_dp     <= w_act_dp_nxt;
            r_an_n       <= w_an_nxt;
            r_dp_n       <= w_on_nxt ? ~w_act_dp_nxt[w_idx_nxt] : SEG_OFF;
            r_code       <= w_act_dig_nxt[4*w_idx_nxt +: 4];
            r_frame_done <= w_last_nxt;
        end
    end

    assign bus.an_n       = r_an_n;
    assign bus.dp_n       = r_dp_n;
    assign bus.dig_code   = r_code;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scenarios for the scan controller with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FL = ND * RD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;
    int   cyc = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Expected anode pattern for cycle c after reset release
    function automatic logic [ND-1:0] exp_an(input int c, input logic [ND-1:0] en);
        int p = c % FL;
        int s = p / RD;
        return ((p % RD) >= BC && en[s]) ? ~(ND'(1) << s) : {ND{1'b1}};
    endfunction

    function automatic logic [3:0] exp_code(input int c, input logic [15:0] data);
        int s = (c % FL) / RD;
        return data[4*s +: 4];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        bus.load = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.digit_en = '1;
        bus.dp_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] dp);
        bus.digits_in = d;
        bus.dp_in = dp;
        bus.load = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load_word(16'hFFFF, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        bus.load = 1'b0;
        n_chk++; if (bus.an_n !== 4'b1111) $display("FAIL reset_an got=%b exp=1111", bus.an_n); else n_pass++;
        n_chk++; if (bus.dp_n !== 1'b1) $display("FAIL reset_dp got=%b exp=1", bus.dp_n); else n_pass++;
        n_chk++; if (bus.dig_code !== 4'h0) $display("FAIL reset_code got=%h exp=0", bus.dig_code); else n_pass++;
        n_chk++; if (bus.frame_done !== 1'b0) $display("FAIL reset_fd got=%b exp=0", bus.frame_done); else n_pass++;
        do_reset();
        repeat (BC) begin
            n_chk++; if (bus.an_n !== 4'b1111) $display("FAIL reset_blank_an cyc=%0d got=%b exp=1111", cyc, bus.an_n); else n_pass++;
            tick();
        end
        n_chk++; if (bus.an_n !== 4'b1110) $display("FAIL first_anode cyc=%0d got=%b exp=1110", cyc, bus.an_n); else n_pass++;
    endtask

    task automatic test_first_frame;
        do_reset();
        while (cyc < 48) begin
            if (cyc == 0) load_word(16'h4321, 4'h0);
            n_chk++; if (bus.an_n !== exp_an(cyc, 4'hF)) $display("FAIL ff_an cyc=%0d got=%b exp=%b", cyc, bus.an_n, exp_an(cyc, 4'hF)); else n_pass++;
            n_chk++; if (bus.dig_code !== exp_code(cyc, cyc < FL ? 16'h0 : 16'h4321)) $display("FAIL ff_code cyc=%0d got=%h exp=%h", cyc, bus.dig_code, exp_code(cyc, cyc < FL ? 16'h0 : 16'h4321)); else n_pass++;
            n_chk++; if (bus.frame_done !== (cyc == 31)) $display("FAIL ff_fd cyc=%0d got=%b exp=%b", cyc, bus.frame_done, cyc == 31); else n_pass++;
            tick();
        end
    endtask

    task automatic test_mid_frame_load;
        logic [15:0] d;
        do_reset();
        while (cyc < 72) begin
            if (cyc == 0) load_word(16'h4321, 4'h0);
            if (cyc == 42) load_word(16'h8765, 4'h0);
            d = cyc < FL ? 16'h0 : cyc < 2*FL ? 16'h4321 : 16'h8765;
            n_chk++; if (bus.dig_code !== exp_code(cyc, d)) $display("FAIL mid_code cyc=%0d got=%h exp=%h", cyc, bus.dig_code, exp_code(cyc, d)); else n_pass++;
            n_chk++; if (bus.an_n !== exp_an(cyc, 4'hF)) $display("FAIL mid_an cyc=%0d got=%b exp=%b", cyc, bus.an_n, exp_an(cyc, 4'hF)); else n_pass++;
            tick();
        end
    endtask

    task automatic test_coincident_load;
        logic [15:0] d;
        do_reset();
        while (cyc < 72) begin
            if (cyc == 0) load_word(16'h4321, 4'h0);
            if (cyc == 40) load_word(16'h1111, 4'h0);
            if (cyc == 50) load_word(16'h2222, 4'h0);
            if (cyc == 63) load_word(16'hABCD, 4'h0);
            d = cyc < FL ? 16'h0 : cyc < 2*FL ? 16'h4321 : 16'hABCD;
            n_chk++; if (bus.dig_code !== exp_code(cyc, d)) $display("FAIL coin_code cyc=%0d got=%h exp=%h", cyc, bus.dig_code, exp_code(cyc, d)); else n_pass++;
            n_chk++; if (bus.an_n !== exp_an(cyc, 4'hF)) $display("FAIL coin_an cyc=%0d got=%b exp=%b", cyc, bus.an_n, exp_an(cyc, 4'hF)); else n_pass++;
            tick();
        end
    endtask

    task automatic test_last_wins;
        logic [15:0] d;
        logic        dp;
        do_reset();
        while (cyc < 64) begin
            if (cyc == 5) load_word(16'h1111, 4'b0001);
            if (cyc == 20) load_word(16'h9F0E, 4'b0100);
            d = cyc < FL ? 16'h0 : 16'h9F0E;
            dp = !(cyc >= FL && cyc % FL >= 2*RD + BC && cyc % FL < 3*RD);
            n_chk++; if (bus.dig_code !== exp_code(cyc, d)) $display("FAIL last_code cyc=%0d got=%h exp=%h", cyc, bus.dig_code, exp_code(cyc, d)); else n_pass++;
            n_chk++; if (bus.dp_n !== dp) $display("FAIL last_dp cyc=%0d got=%b exp=%b", cyc, bus.dp_n, dp); else n_pass++;
            tick();
        end
    endtask

    task automatic test_digit_en;
        do_reset();
        bus.digit_en = 4'b0101;
        while (cyc < 64) begin
            if (cyc == 0) load_word(16'h4321, 4'b0010);
            n_chk++; if (bus.an_n !== exp_an(cyc, 4'b0101)) $display("FAIL en_an cyc=%0d got=%b exp=%b", cyc, bus.an_n, exp_an(cyc, 4'b0101)); else n_pass++;
            n_chk++; if (bus.dp_n !== 1'b1) $display("FAIL en_dp cyc=%0d got=%b exp=1", cyc, bus.dp_n); else n_pass++;
            tick();
        end
    endtask

    task automatic test_en_live;
        do_reset();
        while (cyc < 4) tick();
        bus.digit_en = 4'b1110;
        n_chk++; if (bus.an_n !== 4'b1110) $display("FAIL live_on cyc=%0d got=%b exp=1110", cyc, bus.an_n); else n_pass++;
        tick();
        n_chk++; if (bus.an_n !== 4'b1111) $display("FAIL live_off cyc=%0d got=%b exp=1111", cyc, bus.an_n); else n_pass++;
        bus.digit_en = 4'b1111;
        tick();
        n_chk++; if (bus.an_n !== 4'b1110) $display("FAIL live_back cyc=%0d got=%b exp=1110", cyc, bus.an_n); else n_pass++;
        tick();
        tick();
        n_chk++; if (bus.an_n !== 4'b1111) $display("FAIL live_blank cyc=%0d got=%b exp=1111", cyc, bus.an_n); else n_pass++;
    endtask

    task automatic test_reset_mid_drive;
        do_reset();
        load_word(16'h4321, 4'h0);
        while (cyc < 45) tick();
        n_chk++; if (bus.an_n !== 4'b1101) $display("FAIL rmd_pre_an got=%b exp=1101", bus.an_n); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_chk++; if (bus.dp_n !== 1'b1) $display("FAIL rmd_dp got=%b exp=1", bus.dp_n); else n_pass++;
        n_chk++; if (bus.frame_done !== 1'b0) $display("FAIL rmd_fd got=%b exp=0", bus.frame_done); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            n_chk++; if (bus.an_n !== exp_an(k, 4'hF)) $display("FAIL rmd_an k=%0d got=%b exp=%b", k, bus.an_n, exp_an(k, 4'hF)); else n_pass++;
            n_chk++; if (bus.dig_code !== 4'h0) $display("FAIL rmd_code k=%0d got=%h exp=0", k, bus.dig_code); else n_pass++;
            tick();
        end
    endtask

    task automatic test_long_scan;
        int last_fd = -1;
        int n_fd = 0;
        int prev = -1;
        int cur;
        do_reset();
        load_word(16'h4321, 4'h0);
        while (cyc < 10*FL) begin
            cur = -1;
            for (int i = 0; i < ND; i++) if (!bus.an_n[i]) cur = i;
            n_chk++; if ($countones(~bus.an_n) > 1) $display("FAIL scan_onehot cyc=%0d got=%b exp=at most one low", cyc, bus.an_n); else n_pass++;
            n_chk++; if (cur >= 0 && prev >= 0 && cur != prev) $display("FAIL scan_noblank cyc=%0d got=%0d exp=%0d or blank", cyc, cur, prev); else n_pass++;
            if (bus.frame_done) begin
                n_chk++; if (cyc - last_fd !== (last_fd < 0 ? cyc + 1 : FL)) $display("FAIL scan_fd_period cyc=%0d got=%0d exp=%0d", cyc, cyc - last_fd, FL); else n_pass++;
                last_fd = cyc;
                n_fd++;
            end
            prev = cur;
            tick();
        end
        n_chk++; if (n_fd !== 10) $display("FAIL scan_fd_count got=%0d exp=10", n_fd); else n_pass++;
    endtask

    initial begin
        bus.digits_in = '0;
        bus.dp_in = '0;
        bus.digit_en = '1;
        bus.load = 1'b0;
        test_reset();
        test_first_frame();
        test_mid_frame_load();
        test_coincident_load();
        test_last_wins();
        test_digit_en();
        test_en_live();
        test_reset_mid_drive();
        test_long_scan();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
